// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified word-addressed memory between the fetch port and the
// load/store port: one access per grant, data first, fetch protected from starvation.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_WORDS  = 64,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  input  logic [DATA_W-1:0] mem_memData,
  output logic              busy
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic              port_d_r;
  logic              we_r;
  logic              in_range_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              i_rvalid_r;
  logic [DATA_W-1:0] i_rdata_r;
  logic              d_rvalid_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              d_err_r;
  logic              busy_r;

  logic              arb_en_s;
  logic              d_win_s;
  logic              d_gnt_s;
  logic              i_gnt_s;
  logic [ADDR_W-1:0] gnt_addr_s;
  logic              gnt_in_range_s;
  logic              gnt_we_s;
  logic [DATA_W-1:0] rdata_s;

  // Grant decision: only outside ACCESS and never while reset is high
  always_comb begin
    arb_en_s       = 1'b0;
    d_win_s        = 1'b0;
    gnt_addr_s     = i_addr;
    gnt_in_range_s = 1'b0;
    if (!reset && (state_r != ACCESS)) begin
      arb_en_s = 1'b1;
    end else begin
      arb_en_s = 1'b0;
    end
    d_win_s = d_req && (!i_req || (starve_cnt_r < CNT_W'(STARVE_MAX)));
    if (d_win_s) begin
      gnt_addr_s = d_addr;
    end else begin
      gnt_addr_s = i_addr;
    end
    gnt_in_range_s = (gnt_addr_s < ADDR_W'(MEM_WORDS));
  end

  assign d_gnt_s  = arb_en_s && d_win_s;
  assign i_gnt_s  = arb_en_s && i_req && !d_win_s;
  assign gnt_we_s = d_gnt_s && d_we;

  // Word returned to the requester: memory data for in-range reads, zero otherwise
  always_comb begin
    rdata_s = '0;
    if (!we_r && in_range_r) begin
      rdata_s = mem_memData;
    end else begin
      rdata_s = '0;
    end
  end

  // Main FSM with registered memory strobes and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      starve_cnt_r <= '0;
      port_d_r     <= 1'b0;
      we_r         <= 1'b0;
      in_range_r   <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      i_rvalid_r   <= 1'b0;
      i_rdata_r    <= '0;
      d_rvalid_r   <= 1'b0;
      d_rdata_r    <= '0;
      d_err_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      i_rvalid_r  <= 1'b0;
      i_rdata_r   <= '0;
      d_rvalid_r  <= 1'b0;
      d_rdata_r   <= '0;
      d_err_r     <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      busy_r      <= 1'b0;
      case (state_r)
        IDLE, RESP: begin
          if (d_gnt_s || i_gnt_s) begin
            state_r     <= ACCESS;
            port_d_r    <= d_gnt_s;
            we_r        <= gnt_we_s;
            in_range_r  <= gnt_in_range_s;
            mem_addr_r  <= gnt_addr_s;
            mem_wdata_r <= d_gnt_s ? d_wdata : '0;
            mem_read_r  <= !gnt_we_s && gnt_in_range_s;
            mem_write_r <= gnt_we_s && gnt_in_range_s;
            busy_r      <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          state_r <= RESP;
          if (port_d_r) begin
            d_rvalid_r <= 1'b1;
            d_rdata_r  <= rdata_s;
            d_err_r    <= !in_range_r;
          end else begin
            i_rvalid_r <= 1'b1;
            i_rdata_r  <= rdata_s;
          end
        end
        default: state_r <= IDLE;
      endcase
      // Counts data grants that fetch has been waiting through
      if (!i_req || i_gnt_s) begin
        starve_cnt_r <= '0;
      end else if (d_gnt_s && (starve_cnt_r < CNT_W'(STARVE_MAX))) begin
        starve_cnt_r <= starve_cnt_r + 1'b1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  assign i_gnt         = i_gnt_s;
  assign d_gnt         = d_gnt_s;
  assign i_rvalid      = i_rvalid_r;
  assign i_rdata       = i_rdata_r;
  assign d_rvalid      = d_rvalid_r;
  assign d_rdata       = d_rdata_r;
  assign d_err         = d_err_r;
  assign mem_address   = mem_addr_r;
  assign mem_writeData = mem_wdata_r;
  assign mem_memRead   = mem_read_r;
  // A write caught by reset must never reach the memory
  assign mem_memWrite  = mem_write_r && !reset;
  assign busy          = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model of the shared memory port.
module tb_mem_port_arbiter;
  localparam int MW = 64;
  localparam int SM = 3;

  logic        clk, reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic [31:0] mem_address, mem_writeData, mem_memData;
  logic        mem_memRead, mem_memWrite, busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(MW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_writeData(mem_writeData), .mem_memRead(mem_memRead),
    .mem_memWrite(mem_memWrite), .mem_memData(mem_memData), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initv(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return 32'hA500_0000 + 32'(a) * 32'h0001_0101;
  endfunction

  // Memory device: combinational read, write at the clock edge, preloaded on reset
  logic [31:0] mem [0:MW-1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MW; i++) mem[i] <= initv(i);
    end else if (mem_memWrite && mem_address < 32'(MW)) begin
      mem[mem_address[5:0]] <= mem_writeData;
    end
  end
  assign mem_memData = (mem_address < 32'(MW)) ? mem[mem_address[5:0]] : 32'h0;

  // Reference model: list of granted transactions and the memory image they imply
  typedef struct {
    bit          port;
    bit          we;
    bit          inr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
  } txn_t;

  txn_t        q[$];
  logic [31:0] ref_mem [0:MW-1];
  int          checks = 0, errors = 0, cyc = 0;
  int          waited = 0;
  bit          slot_taken = 1'b0;
  logic        obs_dg, obs_ig, obs_mr, obs_mw, obs_drv, obs_derr, obs_irv;
  logic [31:0] obs_drd, obs_ird;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    txn_t a, r, t;
    bit   ha, hr, eg_d, eg_i;
    ha = 1'b0; hr = 1'b0; eg_d = 1'b0; eg_i = 1'b0;
    #1;
    obs_dg = d_gnt; obs_ig = i_gnt; obs_mr = mem_memRead; obs_mw = mem_memWrite;
    obs_drv = d_rvalid; obs_drd = d_rdata; obs_derr = d_err;
    obs_irv = i_rvalid; obs_ird = i_rdata;
    if (reset) begin
      chk("rst_d_gnt", d_gnt, 32'd0);
      chk("rst_i_gnt", i_gnt, 32'd0);
      chk("rst_memwrite", mem_memWrite, 32'd0);
    end else begin
      // the port is free every other cycle after a grant; data wins unless fetch waited SM grants
      eg_d = !slot_taken && d_req && (!i_req || waited < SM);
      eg_i = !slot_taken && i_req && !eg_d;
      foreach (q[k]) begin
        if (q[k].g + 1 == cyc) begin a = q[k]; ha = 1'b1; end
        if (q[k].g + 2 == cyc) begin r = q[k]; hr = 1'b1; end
      end
      chk("d_gnt", d_gnt, eg_d);
      chk("i_gnt", i_gnt, eg_i);
      chk("busy", busy, ha);
      chk("mem_read", mem_memRead, ha && !a.we && a.inr);
      chk("mem_write", mem_memWrite, ha && a.we && a.inr);
      chk("mem_addr", mem_address, ha ? a.addr : 32'h0);
      if (ha && a.we && a.inr) chk("mem_wdata", mem_writeData, a.wdata);
      chk("i_rvalid", i_rvalid, hr && !r.port);
      chk("i_rdata", i_rdata, (hr && !r.port) ? r.rdata : 32'h0);
      chk("d_rvalid", d_rvalid, hr && r.port);
      chk("d_rdata", d_rdata, (hr && r.port) ? r.rdata : 32'h0);
      chk("d_err", d_err, hr && r.port && !r.inr);
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      slot_taken = 1'b0;
      waited = 0;
      for (int i = 0; i < MW; i++) ref_mem[i] = initv(i);
    end else begin
      if (eg_d || eg_i) begin
        t.port  = eg_d;
        t.we    = eg_d && d_we;
        t.addr  = eg_d ? d_addr : i_addr;
        t.wdata = d_wdata;
        t.inr   = (t.addr < 32'(MW));
        t.g     = cyc;
        if (t.we && t.inr) ref_mem[t.addr[5:0]] = t.wdata;
        t.rdata = (!t.we && t.inr) ? ref_mem[t.addr[5:0]] : 32'h0;
        q.push_back(t);
      end
      slot_taken = eg_d || eg_i;
      if (!i_req || eg_i) waited = 0;
      else if (eg_d && waited < SM) waited++;
    end
    cyc++;
    while (q.size() > 0 && q[0].g + 2 < cyc) void'(q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    int          lat, ngr;
    logic [7:0]  gseq;
    logic [31:0] got[$];
    int          gcyc[$];
    int          ia;
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    @(negedge clk);
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("reset_busy", busy, 32'd0);
    chk("reset_rvalid", {i_rvalid, d_rvalid}, 32'd0);

    // 1: data read of address 5
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd5;
    cycle(); chk("t1_gnt", obs_dg, 32'd1); d_req = 1'b0;
    cycle(); chk("t1_memread", obs_mr, 32'd1);
    cycle(); chk("t1_rvalid", obs_drv, 32'd1); chk("t1_rdata", obs_drd, 32'hDEADBEEF);
    cycle();

    // 2: write 0x1234 to address 10, then read it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd10; d_wdata = 32'h1234;
    cycle(); d_req = 1'b0;
    cycle(); chk("t2_memwrite", obs_mw, 32'd1);
    cycle(); chk("t2_wr_rdata", {obs_drv, obs_drd}, {1'b1, 32'h0});
    chk("t2_one_write", obs_mw, 32'd0);
    d_req = 1'b1; d_we = 1'b0;
    cycle(); d_req = 1'b0;
    cycle(); cycle(); chk("t2_readback", obs_drd, 32'h1234);
    cycle();

    // 3: both ports held: D,D,D,I pattern, fetch answered within 8 cycles
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd7; i_req = 1'b1; i_addr = 32'd3;
    lat = -1; ngr = 0; gseq = 8'h0;
    for (int n = 0; n < 24; n++) begin
      cycle();
      if (obs_irv && lat < 0) lat = n;
      if ((obs_dg || obs_ig) && ngr < 8) begin
        gseq = {gseq[6:0], obs_dg};
        ngr++;
      end
    end
    chk("t3_pattern", gseq, 8'b1110_1110);
    chk("t3_latency_ok", (lat >= 0 && lat <= 8), 32'd1);
    d_req = 1'b0; i_req = 1'b0;
    cycle(); cycle(); cycle();

    // 4: out-of-range data write and fetch
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd64; d_wdata = 32'hCAFE;
    cycle(); d_req = 1'b0;
    cycle(); chk("t4_no_write", obs_mw, 32'd0);
    cycle(); chk("t4_err", {obs_drv, obs_derr}, 32'd3); chk("t4_rdata", obs_drd, 32'h0);
    i_req = 1'b1; i_addr = 32'd70;
    cycle(); i_req = 1'b0;
    cycle(); cycle(); chk("t4_fetch", {obs_irv, obs_ird}, {1'b1, 32'h0});
    cycle();

    // 5: reset during the access of a write
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd20; d_wdata = 32'h5555;
    cycle(); d_req = 1'b0; reset = 1'b1;
    cycle(); chk("t5_no_write", obs_mw, 32'd0);
    reset = 1'b0;
    cycle(); chk("t5_no_rvalid", {obs_drv, obs_irv}, 32'd0);
    chk("t5_idle", busy, 32'd0);
    cycle();

    // 6: fetch-only stream of addresses 0,1,2
    i_req = 1'b1; i_addr = 32'd0; ia = 0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (obs_irv) got.push_back(obs_ird);
      if (obs_ig) begin
        gcyc.push_back(n);
        ia++;
        if (ia < 3) i_addr = 32'(ia); else i_req = 1'b0;
      end
    end
    chk("t6_count", got.size(), 32'd3);
    for (int k = 0; k < 3; k++) chk("t6_data", (k < got.size()) ? got[k] : 32'hX, initv(k));
    chk("t6_spacing", (gcyc.size() == 3) ? (gcyc[2] - gcyc[0]) : -1, 32'd4);

    // Random traffic from both masters against the reference model
    for (int n = 0; n < 600; n++) begin
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1; d_we = $urandom_range(0, 1); d_wdata = $urandom;
        case ($urandom_range(0, 7))
          0: d_addr = 32'd64;
          1: d_addr = 32'h100 + 32'($urandom_range(0, 63));
          2: d_addr = 32'hFFFF_FFFF;
          default: d_addr = 32'($urandom_range(0, 63));
        endcase
      end
      if (!i_req && $urandom_range(0, 1) != 0) begin
        i_req = 1'b1;
        i_addr = ($urandom_range(0, 9) == 0) ? 32'h140 : 32'($urandom_range(0, 63));
      end
      cycle();
      if (obs_dg) d_req = 1'b0;
      if (obs_ig) i_req = 1'b0;
    end
    d_req = 1'b0; i_req = 1'b0;
    cycle(); cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
